// File: rtl/rename_map_table.sv
// rename_map_table: speculative register map for the rename stage.
//   Pops one free physical tag from free_list per renamed destination and
//   maps architectural to physical registers. It also keeps a retirement
//   (architectural) map that is used to restore state on a mispredict, and
//   tracks per-entry ready bits from the CDB.
// Ports:
//   clock, reset_n                       clock, asynchronous active-low reset
//   rn_valid/rn_ready, rn_rs1/rs2/rd,    rename request handshake and operands
//   rn_rd_valid
//   fl_rd, fl_tag, fl_empty              free_list pop (data valid next cycle)
//   fl_wr, fl_wdata                      free_list push of a freed tag
//   out_valid, out_tag1/2, out_rdy1/2,   renamed instruction, one cycle after
//   out_dest_tag, out_old_tag            accept
//   cdb_valid, cdb_tag                   completion broadcast (ready wakeup)
//   rt_valid, rt_rd, rt_tag              retirement of a destination write
//   recover                              restore speculative map from arch map
// Build option: define MAP_TABLE_CDB_BYPASS_EN so that a CDB broadcast in the
//   accept cycle also marks the matching renamed sources ready.

`ifndef CDB_BITS
`define CDB_BITS 6
`endif

module rename_map_table #(
  parameter int unsigned N_ARCH = 32,
  parameter int unsigned TAG_W  = `CDB_BITS,
  localparam int unsigned IDX_W = $clog2(N_ARCH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rn_valid,
  output logic             rn_ready,
  input  logic [IDX_W-1:0] rn_rs1,
  input  logic [IDX_W-1:0] rn_rs2,
  input  logic [IDX_W-1:0] rn_rd,
  input  logic             rn_rd_valid,
  output logic             fl_rd,
  input  logic [TAG_W-1:0] fl_tag,
  input  logic             fl_empty,
  output logic             fl_wr,
  output logic [TAG_W-1:0] fl_wdata,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag1,
  output logic [TAG_W-1:0] out_tag2,
  output logic             out_rdy1,
  output logic             out_rdy2,
  output logic [TAG_W-1:0] out_dest_tag,
  output logic [TAG_W-1:0] out_old_tag,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic             rt_valid,
  input  logic [IDX_W-1:0] rt_rd,
  input  logic [TAG_W-1:0] rt_tag,
  input  logic             recover
);

  // Map state
  logic [N_ARCH-1:0][TAG_W-1:0] spec_tag_q, spec_tag_d;
  logic [N_ARCH-1:0]            spec_rdy_q, spec_rdy_d;
  logic [N_ARCH-1:0][TAG_W-1:0] arch_q, arch_d;

  // Rename stage register and its registered source/old tags
  logic             stg_valid_q, stg_valid_d;
  logic             stg_alloc_q, stg_alloc_d;
  logic [IDX_W-1:0] stg_rd_q, stg_rd_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, old_q, old_d;
  logic             rdy1_q, rdy1_d, rdy2_q, rdy2_d;

  // Freed-tag push register
  logic             fl_wr_q, fl_wr_d;
  logic [TAG_W-1:0] fl_wdata_q, fl_wdata_d;

  // Low in reset and for the first edge after release; keeps fl_rd quiet in reset
  logic run_q;

  logic             alloc_needed, accept, stg_write, cdb_en;
  logic [TAG_W:0]   src1_c, src2_c;

  // Source lookup returning {ready, tag}; byp selects the older stage's fl_tag
  function automatic logic [TAG_W:0] src_lookup(
    input logic [IDX_W-1:0] rs,
    input logic [TAG_W-1:0] map_tag,
    input logic             map_rdy,
    input logic             byp,
    input logic [TAG_W-1:0] byp_tag
  );
    if (rs == '0) return {1'b1, TAG_W'(0)};
    if (byp)      return {1'b0, byp_tag};
    return {map_rdy, map_tag};
  endfunction

  assign alloc_needed = rn_rd_valid && (rn_rd != '0);
  assign rn_ready     = run_q && !recover && !(alloc_needed && fl_empty);
  assign accept       = rn_valid && rn_ready;
  assign fl_rd        = accept && alloc_needed;
  assign stg_write    = stg_valid_q && stg_alloc_q;
  assign cdb_en       = cdb_valid && (cdb_tag != '0);

  assign out_valid    = stg_valid_q;
  assign out_dest_tag = stg_write ? fl_tag : '0;
  assign out_tag1     = tag1_q;
  assign out_tag2     = tag2_q;
  assign out_rdy1     = rdy1_q;
  assign out_rdy2     = rdy2_q;
  assign out_old_tag  = old_q;
  assign fl_wr        = fl_wr_q;
  assign fl_wdata     = fl_wdata_q;

  // Next-state: CDB wakeup, stage write, retire, recover, operand capture
  always_comb begin
    spec_tag_d  = spec_tag_q;
    spec_rdy_d  = spec_rdy_q;
    arch_d      = arch_q;
    fl_wr_d     = 1'b0;
    fl_wdata_d  = '0;
    stg_valid_d = accept;
    stg_alloc_d = accept && alloc_needed;
    stg_rd_d    = accept ? rn_rd : '0;
    tag1_d      = '0;
    tag2_d      = '0;
    old_d       = '0;
    rdy1_d      = 1'b0;
    rdy2_d      = 1'b0;

    // Sources see the older stage instruction's mapping as already written
    src1_c = src_lookup(rn_rs1, spec_tag_q[rn_rs1], spec_rdy_q[rn_rs1],
                        stg_write && (stg_rd_q == rn_rs1), fl_tag);
    src2_c = src_lookup(rn_rs2, spec_tag_q[rn_rs2], spec_rdy_q[rn_rs2],
                        stg_write && (stg_rd_q == rn_rs2), fl_tag);

    for (int r = 0; r < N_ARCH; r++) begin
      if (cdb_en && (spec_tag_q[r] == cdb_tag)) spec_rdy_d[r] = 1'b1;
    end

    // A newly written mapping overrides any wakeup of the entry's old tag
    if (stg_write) begin
      spec_tag_d[stg_rd_q] = fl_tag;
      spec_rdy_d[stg_rd_q] = 1'b0;
    end

    if (rt_valid && (rt_rd != '0)) begin
      fl_wr_d       = 1'b1;
      fl_wdata_d    = arch_q[rt_rd];
      arch_d[rt_rd] = rt_tag;
    end

    // Recover copies the arch map including this cycle's retire update
    if (recover) begin
      for (int r = 0; r < N_ARCH; r++) begin
        spec_tag_d[r] = arch_d[r];
        spec_rdy_d[r] = 1'b1;
      end
    end

    if (accept) begin
      tag1_d = src1_c[TAG_W-1:0];
      tag2_d = src2_c[TAG_W-1:0];
      rdy1_d = src1_c[TAG_W];
      rdy2_d = src2_c[TAG_W];
`ifdef MAP_TABLE_CDB_BYPASS_EN
      if (cdb_en && (src1_c[TAG_W-1:0] == cdb_tag)) rdy1_d = 1'b1;
      if (cdb_en && (src2_c[TAG_W-1:0] == cdb_tag)) rdy2_d = 1'b1;
`endif
      if (alloc_needed) begin
        old_d = (stg_write && (stg_rd_q == rn_rd)) ? fl_tag : spec_tag_q[rn_rd];
      end
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < N_ARCH; r++) begin
        spec_tag_q[r] <= TAG_W'(r + 1);
        arch_q[r]     <= TAG_W'(r + 1);
      end
      spec_rdy_q  <= '1;
      stg_valid_q <= 1'b0;
      stg_alloc_q <= 1'b0;
      stg_rd_q    <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      old_q       <= '0;
      rdy1_q      <= 1'b0;
      rdy2_q      <= 1'b0;
      fl_wr_q     <= 1'b0;
      fl_wdata_q  <= '0;
      run_q       <= 1'b0;
    end else begin
      spec_tag_q  <= spec_tag_d;
      spec_rdy_q  <= spec_rdy_d;
      arch_q      <= arch_d;
      stg_valid_q <= stg_valid_d;
      stg_alloc_q <= stg_alloc_d;
      stg_rd_q    <= stg_rd_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      old_q       <= old_d;
      rdy1_q      <= rdy1_d;
      rdy2_q      <= rdy2_d;
      fl_wr_q     <= fl_wr_d;
      fl_wdata_q  <= fl_wdata_d;
      run_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// tb_rename_map_table: directed and randomized bench for rename_map_table,
//   checked against an array-based model of the speculative/arch maps.

`ifndef CDB_BITS
`define CDB_BITS 6
`endif

module tb_rename_map_table;
  localparam int unsigned N_ARCH = 32;
  localparam int unsigned TAG_W  = `CDB_BITS;
`ifdef MAP_TABLE_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset_n;
  logic             rn_valid, rn_ready, rn_rd_valid;
  logic [4:0]       rn_rs1, rn_rs2, rn_rd;
  logic             fl_rd, fl_empty, fl_wr;
  logic [TAG_W-1:0] fl_tag, fl_wdata;
  logic             out_valid, out_rdy1, out_rdy2;
  logic [TAG_W-1:0] out_tag1, out_tag2, out_dest_tag, out_old_tag;
  logic             cdb_valid, rt_valid, recover;
  logic [TAG_W-1:0] cdb_tag, rt_tag;
  logic [4:0]       rt_rd;

  rename_map_table dut (
    .clock(clock), .reset_n(reset_n),
    .rn_valid(rn_valid), .rn_ready(rn_ready),
    .rn_rs1(rn_rs1), .rn_rs2(rn_rs2), .rn_rd(rn_rd), .rn_rd_valid(rn_rd_valid),
    .fl_rd(fl_rd), .fl_tag(fl_tag), .fl_empty(fl_empty),
    .fl_wr(fl_wr), .fl_wdata(fl_wdata),
    .out_valid(out_valid), .out_tag1(out_tag1), .out_tag2(out_tag2),
    .out_rdy1(out_rdy1), .out_rdy2(out_rdy2),
    .out_dest_tag(out_dest_tag), .out_old_tag(out_old_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .rt_valid(rt_valid), .rt_rd(rt_rd), .rt_tag(rt_tag),
    .recover(recover)
  );

  always #5 clock = ~clock;

  // Reference model
  logic [TAG_W-1:0] m_tag  [N_ARCH];
  bit               m_rdy  [N_ARCH];
  logic [TAG_W-1:0] m_arch [N_ARCH];
  bit               s_valid, s_alloc, s_r1, s_r2;
  logic [4:0]       s_rd;
  logic [TAG_W-1:0] s_t1, s_t2, s_old;
  bit               m_flwr;
  logic [TAG_W-1:0] m_flwdata;
  logic [TAG_W-1:0] pend_tag;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < N_ARCH; r++) begin
      m_tag[r]  = TAG_W'(r + 1);
      m_arch[r] = TAG_W'(r + 1);
      m_rdy[r]  = 1'b1;
    end
    s_valid = 0; s_alloc = 0; s_rd = 0;
    s_t1 = 0; s_t2 = 0; s_old = 0; s_r1 = 0; s_r2 = 0;
    m_flwr = 0; m_flwdata = 0;
  endtask

  task automatic idle();
    rn_valid = 0; rn_rs1 = 0; rn_rs2 = 0; rn_rd = 0; rn_rd_valid = 0;
    fl_empty = 0; cdb_valid = 0; cdb_tag = 0;
    rt_valid = 0; rt_rd = 0; rt_tag = 0; recover = 0;
  endtask

  task automatic ren(input int rs1, input int rs2, input int rd, input bit rdv);
    idle();
    rn_valid = 1; rn_rs1 = 5'(rs1); rn_rs2 = 5'(rs2); rn_rd = 5'(rd); rn_rd_valid = rdv;
  endtask

  // One clock cycle: check this cycle's outputs, advance the model, clock
  task automatic step();
    bit an, exp_rdy, exp_flrd, acc, cdb_on;
    logic [TAG_W-1:0] vt [N_ARCH];
    bit               vr [N_ARCH];
    logic [TAG_W-1:0] t1, t2, old;
    bit               r1, r2;
    #1;
    an       = rn_rd_valid && (rn_rd != 0);
    exp_rdy  = !recover && !(an && fl_empty);
    exp_flrd = rn_valid && exp_rdy && an;
    acc      = rn_valid && exp_rdy;
    cdb_on   = cdb_valid && (cdb_tag != 0);
    chk("rn_ready", 32'(rn_ready), 32'(exp_rdy));
    chk("fl_rd", 32'(fl_rd), 32'(exp_flrd));
    chk("out_valid", 32'(out_valid), 32'(s_valid));
    chk("out_dest_tag", 32'(out_dest_tag), (s_valid && s_alloc) ? 32'(fl_tag) : 32'd0);
    chk("out_tag1", 32'(out_tag1), 32'(s_t1));
    chk("out_tag2", 32'(out_tag2), 32'(s_t2));
    chk("out_rdy1", 32'(out_rdy1), 32'(s_r1));
    chk("out_rdy2", 32'(out_rdy2), 32'(s_r2));
    chk("out_old_tag", 32'(out_old_tag), 32'(s_old));
    chk("fl_wr", 32'(fl_wr), 32'(m_flwr));
    chk("fl_wdata", 32'(fl_wdata), 32'(m_flwdata));

    // Program-order view: the older instruction's new mapping is visible
    for (int r = 0; r < N_ARCH; r++) begin
      vt[r] = m_tag[r];
      vr[r] = m_rdy[r];
    end
    if (s_valid && s_alloc) begin
      vt[s_rd] = fl_tag;
      vr[s_rd] = 1'b0;
    end
    if (rn_rs1 == 0) begin t1 = 0; r1 = 1; end
    else begin t1 = vt[rn_rs1]; r1 = vr[rn_rs1] || (BYP && cdb_on && cdb_tag == t1); end
    if (rn_rs2 == 0) begin t2 = 0; r2 = 1; end
    else begin t2 = vt[rn_rs2]; r2 = vr[rn_rs2] || (BYP && cdb_on && cdb_tag == t2); end
    old = an ? vt[rn_rd] : '0;

    if (cdb_on)
      for (int r = 0; r < N_ARCH; r++) if (m_tag[r] == cdb_tag) m_rdy[r] = 1'b1;
    if (s_valid && s_alloc) begin
      m_tag[s_rd] = fl_tag;
      m_rdy[s_rd] = 1'b0;
    end
    if (rt_valid && rt_rd != 0) begin
      m_flwr = 1; m_flwdata = m_arch[rt_rd]; m_arch[rt_rd] = rt_tag;
    end else begin
      m_flwr = 0; m_flwdata = 0;
    end
    if (recover)
      for (int r = 0; r < N_ARCH; r++) begin m_tag[r] = m_arch[r]; m_rdy[r] = 1'b1; end
    s_valid = acc;
    s_alloc = acc && an;
    s_rd    = acc ? rn_rd : 5'd0;
    s_t1    = acc ? t1 : '0;
    s_t2    = acc ? t2 : '0;
    s_r1    = acc ? r1 : 1'b0;
    s_r2    = acc ? r2 : 1'b0;
    s_old   = acc ? old : '0;

    @(posedge clock);
    #1;
    // Free list delivers the popped tag the cycle after fl_rd
    if (exp_flrd) fl_tag = pend_tag;
    pend_tag = TAG_W'($urandom_range(33, 63));
    @(negedge clock);
  endtask

  initial begin
    idle();
    reset_n  = 0;
    fl_tag   = 0;
    pend_tag = 33;
    model_reset();

    // In reset: a live allocating request must not pop
    rn_valid = 1; rn_rd = 5'd3; rn_rd_valid = 1;
    #12;
    chk("rst_rn_ready", 32'(rn_ready), 0);
    chk("rst_fl_rd", 32'(fl_rd), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_fl_wr", 32'(fl_wr), 0);
    chk("rst_out_tag1", 32'(out_tag1), 0);
    idle();
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);

    // add r3 <- r1, r2 with tag 33
    ren(1, 2, 3, 1); pend_tag = 33; step();
    idle(); #1;
    chk("add_tag1", 32'(out_tag1), 2);
    chk("add_tag2", 32'(out_tag2), 3);
    chk("add_rdy", {30'd0, out_rdy1, out_rdy2}, 3);
    chk("add_dest", 32'(out_dest_tag), 33);
    chk("add_old", 32'(out_old_tag), 4);
    step();

    // Back-to-back dependent pair: r5 <- r1, then r6 <- r5
    ren(1, 0, 5, 1); pend_tag = 35; step();
    ren(5, 0, 6, 1); pend_tag = 36; #1;
    chk("dep_first_dest", 32'(out_dest_tag), 35);
    step();
    idle(); #1;
    chk("dep_valid", 32'(out_valid), 1);
    chk("dep_tag1", 32'(out_tag1), 35);
    chk("dep_rdy1", 32'(out_rdy1), 0);
    step();

    // Free list empty: allocating request stalls, rd=0 request goes through
    ren(1, 2, 4, 1); fl_empty = 1; #1;
    chk("empty_ready", 32'(rn_ready), 0);
    chk("empty_fl_rd", 32'(fl_rd), 0);
    step();
    ren(1, 2, 0, 1); fl_empty = 1; step();
    idle(); #1;
    chk("rd0_valid", 32'(out_valid), 1);
    chk("rd0_dest", 32'(out_dest_tag), 0);
    step();

    // CDB wakeup in an earlier cycle, then a later reader
    ren(0, 0, 7, 1); pend_tag = 37; step();
    idle(); step();
    idle(); cdb_valid = 1; cdb_tag = 37; step();
    ren(7, 0, 0, 0); step();
    idle(); #1;
    chk("cdb_later_rdy1", 32'(out_rdy1), 1);
    step();

    // CDB in the reader's own accept cycle
    ren(0, 0, 8, 1); pend_tag = 38; step();
    idle(); step();
    ren(8, 0, 0, 0); cdb_valid = 1; cdb_tag = 38; step();
    idle(); #1;
    chk("cdb_same_rdy1", 32'(out_rdy1), 32'(BYP));
    step();

    // Retire r3 with tag 33: previous arch tag 4 is freed next cycle
    idle(); rt_valid = 1; rt_rd = 5'd3; rt_tag = 33; step();
    idle(); #1;
    chk("ret_fl_wr", 32'(fl_wr), 1);
    chk("ret_fl_wdata", 32'(fl_wdata), 4);
    step();

    // Rename r9, then recover with a same-cycle retire of r9 as tag 40
    ren(0, 0, 9, 1); pend_tag = 39; step();
    ren(1, 0, 10, 1); recover = 1; rt_valid = 1; rt_rd = 5'd9; rt_tag = 40; #1;
    chk("rec_ready", 32'(rn_ready), 0);
    chk("rec_fl_rd", 32'(fl_rd), 0);
    step();
    ren(9, 0, 0, 0); #1;
    chk("rec_no_valid", 32'(out_valid), 0);
    step();
    idle(); #1;
    chk("rec_tag1", 32'(out_tag1), 40);
    chk("rec_rdy1", 32'(out_rdy1), 1);
    step();

    // Reset asserted mid-operation
    ren(1, 2, 11, 1); rt_valid = 1; rt_rd = 5'd4; rt_tag = 50;
    #2;
    reset_n = 0;
    #1;
    chk("midrst_fl_rd", 32'(fl_rd), 0);
    chk("midrst_fl_wr", 32'(fl_wr), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_dest", 32'(out_dest_tag), 0);
    idle();
    model_reset();
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);

    // Randomized traffic on a small register window to force dependencies
    for (int i = 0; i < 400; i++) begin
      idle();
      rn_valid    = ($urandom_range(0, 9) < 7);
      rn_rs1      = 5'($urandom_range(0, 7));
      rn_rs2      = 5'($urandom_range(0, 7));
      rn_rd       = 5'($urandom_range(0, 7));
      rn_rd_valid = ($urandom_range(0, 9) < 8);
      fl_empty    = ($urandom_range(0, 9) == 0);
      cdb_valid   = ($urandom_range(0, 1) == 1);
      cdb_tag     = ($urandom_range(0, 1) == 1) ? m_tag[$urandom_range(0, 7)]
                                                : TAG_W'($urandom_range(0, 63));
      rt_valid    = ($urandom_range(0, 9) < 3);
      rt_rd       = 5'($urandom_range(0, 7));
      rt_tag      = TAG_W'($urandom_range(1, 63));
      recover     = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
